// File: rtl/axi_slv_burst_responder_if.sv
// axi_slv_burst_responder_if: AXI4 write/read channel bundle between a master and the burst responder
interface axi_slv_burst_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_slv_burst_responder.sv
// axi_slv_burst_responder: AXI4 slave with word memory, FIXED/INCR/WRAP bursts and OKAY/SLVERR/DECERR responses
module axi_slv_burst_responder #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 8
) (
    input logic clock,
    input logic reset,
    axi_slv_burst_responder_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int DEPTH = 2 ** MEM_WORDS_LOG2;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [1:0] err_class(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (32'(a) >= MEM_BYTES) return 2'b11;
        if (size != 3'(SZ) || burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})))
            return 2'b10;
        return 2'b00;
    endfunction

    // WRAP keeps the upper address bits and wraps the low bits inside the (len+1)*bytes window
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr, mask;
        incr = a + (ADDR_WIDTH'(1) << size);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        return burst == 2'b00 ? a : burst == 2'b10 ? ((a & ~mask) | (incr & mask)) : incr;
    endfunction

    function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[MEM_WORDS_LOG2+SZ-1:SZ];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_err;
    logic [8:0]            w_cnt;
    logic                  wl_err, aw_hs, w_hs, w_last_beat;

    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_naddr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst, r_err, ar_err;
    logic [8:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  ar_hs, r_hs, r_last_beat;

    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready && !reset;
    assign w_last_beat = w_cnt == {1'b0, w_len};
    assign ar_hs       = bus.arvalid && bus.arready;
    assign r_hs        = bus.rvalid && bus.rready;
    assign r_last_beat = r_cnt == {1'b0, r_len};
    assign ar_err      = err_class(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
    assign r_naddr     = next_addr(r_addr, r_len, r_size, r_burst);

    // write FSM state register
    always_ff @(posedge clock)
        if (reset) w_state <= W_IDLE;
        else w_state <= w_next;

    // write FSM next state: the beat count, not wlast, ends the data phase
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // write channel outputs; a wlast mismatch overrides the burst's error class
    always_comb begin
        bus.awready = w_state == W_IDLE;
        bus.wready  = w_state == W_DATA;
        bus.bvalid  = w_state == W_RESP;
        bus.bid     = w_id;
        bus.bresp   = w_state == W_RESP ? (wl_err ? 2'b10 : w_err) : 2'b00;
    end

    // write command latch, beat counter and address walk
    always_ff @(posedge clock)
        if (reset) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= '0;
            w_cnt   <= '0;
            wl_err  <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= bus.awid;
            w_addr  <= bus.awaddr;
            w_len   <= bus.awlen;
            w_size  <= bus.awsize;
            w_burst <= bus.awburst;
            w_err   <= err_class(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
            w_cnt   <= '0;
            wl_err  <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 9'd1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            if (bus.wlast != w_last_beat) wl_err <= 1'b1;
        end

    // byte-enabled memory write; erroneous bursts leave memory untouched
    always_ff @(posedge clock)
        if (w_hs && w_err == 2'b00)
            for (int i = 0; i < BYTES; i++)
                if (bus.wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];

    // read FSM state register
    always_ff @(posedge clock)
        if (reset) r_state <= R_IDLE;
        else r_state <= r_next;

    // read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // read channel outputs
    always_comb begin
        bus.arready = r_state == R_IDLE;
        bus.rvalid  = r_state == R_DATA;
        bus.rid     = r_id;
        bus.rdata   = r_data;
        bus.rresp   = r_state == R_DATA ? r_err : 2'b00;
        bus.rlast   = r_state == R_DATA && r_last_beat;
    end

    // read command latch and prefetch of the next beat; a write to the same word this cycle is not yet visible
    always_ff @(posedge clock)
        if (reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_id    <= bus.arid;
            r_addr  <= bus.araddr;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_err   <= ar_err;
            r_cnt   <= '0;
            r_data  <= ar_err == 2'b00 ? mem[word_idx(bus.araddr)] : '0;
        end else if (r_hs && !r_last_beat) begin
            r_cnt  <= r_cnt + 9'd1;
            r_addr <= r_naddr;
            r_data <= r_err == 2'b00 ? mem[word_idx(r_naddr)] : '0;
        end
endmodule

// File: tb/tb_axi_slv_burst_responder.sv
// tb_axi_slv_burst_responder: table-driven burst checks plus backpressure and mid-burst reset sequences
module tb_axi_slv_burst_responder;
    typedef struct {
        bit              wr;
        logic [3:0]      id;
        logic [11:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [31:0]     d0;
        logic [3:0]      strb;
        logic [8:0]      wl;
        logic [1:0]      resp;
        logic [3:0][31:0] e;
    } vec_t;

    logic clock, reset;
    int checks = 0, errors = 0;
    vec_t v [20];

    axi_slv_burst_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4)) ifc ();

    axi_slv_burst_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS_LOG2(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus(ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit wr, logic [3:0] id, logic [11:0] a, logic [7:0] len, logic [2:0] size,
                                logic [1:0] burst, logic [31:0] d0, logic [3:0] strb, logic [8:0] wl,
                                logic [1:0] resp, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] e3);
        vec_t r;
        r.wr = wr; r.id = id; r.addr = a; r.len = len; r.size = size; r.burst = burst;
        r.d0 = d0; r.strb = strb; r.wl = wl; r.resp = resp; r.e = {e3, e2, e1, e0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_write(input vec_t t, input int bdly);
        @(negedge clock);
        ifc.awid = t.id; ifc.awaddr = t.addr; ifc.awlen = t.len; ifc.awsize = t.size;
        ifc.awburst = t.burst; ifc.awvalid = 1'b1;
        for (int k = 0; k < 100 && !ifc.awready; k++) @(negedge clock);
        chk("awready", 64'(ifc.awready), 64'(1));
        @(negedge clock);
        ifc.awvalid = 1'b0;
        for (int i = 0; i <= int'(t.len); i++) begin
            ifc.wvalid = 1'b1; ifc.wdata = t.d0 + 32'(i); ifc.wstrb = t.strb;
            ifc.wlast = 9'(i) == t.wl;
            for (int k = 0; k < 100 && !ifc.wready; k++) @(negedge clock);
            chk("wready", 64'(ifc.wready), 64'(1));
            @(negedge clock);
        end
        ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
        chk("bvalid", 64'(ifc.bvalid), 64'(1));
        chk("bid", 64'(ifc.bid), 64'(t.id));
        chk("bresp", 64'(ifc.bresp), 64'(t.resp));
        for (int k = 0; k < bdly; k++) begin
            @(negedge clock);
            chk("bvalid_hold", 64'(ifc.bvalid), 64'(1));
            chk("bresp_hold", 64'(ifc.bresp), 64'(t.resp));
            chk("bid_hold", 64'(ifc.bid), 64'(t.id));
        end
        ifc.bready = 1'b1;
        @(negedge clock);
        ifc.bready = 1'b0;
        chk("bvalid_drop", 64'(ifc.bvalid), 64'(0));
        chk("awready_back", 64'(ifc.awready), 64'(1));
    endtask

    task automatic do_read(input vec_t t, input bit bp);
        int n;
        logic [31:0] exp_d;
        @(negedge clock);
        ifc.arid = t.id; ifc.araddr = t.addr; ifc.arlen = t.len; ifc.arsize = t.size;
        ifc.arburst = t.burst; ifc.arvalid = 1'b1;
        for (int k = 0; k < 100 && !ifc.arready; k++) @(negedge clock);
        chk("arready", 64'(ifc.arready), 64'(1));
        @(negedge clock);
        ifc.arvalid = 1'b0;
        chk("r_latency", 64'(ifc.rvalid), 64'(1));
        n = 0;
        for (int k = 0; k < 400 && n <= int'(t.len); k++) begin
            if (k > 0) @(negedge clock);
            if (ifc.rvalid) begin
                exp_d = t.len > 8'd3 ? t.d0 + 32'(n) : t.e[n[1:0]];
                chk("rdata", 64'(ifc.rdata), 64'(exp_d));
                chk("rresp", 64'(ifc.rresp), 64'(t.resp));
                chk("rid", 64'(ifc.rid), 64'(t.id));
                chk("rlast", 64'(ifc.rlast), 64'(n == int'(t.len)));
            end
            ifc.rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.rready && ifc.rvalid) n++;
        end
        chk("r_beats", 64'(n), 64'(int'(t.len) + 1));
        @(negedge clock);
        ifc.rready = 1'b0;
        chk("rvalid_drop", 64'(ifc.rvalid), 64'(0));
        chk("arready_back", 64'(ifc.arready), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0; ifc.awvalid = 1'b0;
        ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
        ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0; ifc.arvalid = 1'b0;
        ifc.rready = 1'b0;

        v[0]  = mk(1, 1,  'h010, 3, 2, 1, 'hA0,       'hF, 3,      0, 0, 0, 0, 0);
        v[1]  = mk(0, 2,  'h010, 3, 2, 1, 0,          0,   0,      0, 'hA0, 'hA1, 'hA2, 'hA3);
        v[2]  = mk(1, 3,  'h010, 3, 2, 1, 4,          'hF, 3,      0, 0, 0, 0, 0);
        v[3]  = mk(0, 4,  'h018, 3, 2, 2, 0,          0,   0,      0, 6, 7, 4, 5);
        v[4]  = mk(1, 5,  'h020, 0, 2, 1, 'h11223344, 'hF, 0,      0, 0, 0, 0, 0);
        v[5]  = mk(1, 6,  'h020, 0, 2, 1, 'h0000AB00, 'h2, 0,      0, 0, 0, 0, 0);
        v[6]  = mk(0, 7,  'h020, 0, 2, 1, 0,          0,   0,      0, 'h1122AB44, 0, 0, 0);
        v[7]  = mk(1, 8,  'h400, 1, 2, 1, 'hDEAD0000, 'hF, 1,      3, 0, 0, 0, 0);
        v[8]  = mk(0, 9,  'h400, 1, 2, 1, 0,          0,   0,      3, 0, 0, 0, 0);
        v[9]  = mk(1, 10, 'h020, 0, 1, 1, 'hFFFFFFFF, 'hF, 0,      2, 0, 0, 0, 0);
        v[10] = mk(0, 11, 'h020, 0, 2, 1, 0,          0,   0,      0, 'h1122AB44, 0, 0, 0);
        v[11] = mk(1, 12, 'h030, 1, 2, 3, 'h99,       'hF, 1,      2, 0, 0, 0, 0);
        v[12] = mk(0, 13, 'h010, 2, 2, 2, 0,          0,   0,      2, 0, 0, 0, 0);
        v[13] = mk(1, 14, 'h040, 1, 2, 0, 'h50,       'hF, 1,      0, 0, 0, 0, 0);
        v[14] = mk(0, 15, 'h040, 1, 2, 0, 0,          0,   0,      0, 'h51, 'h51, 0, 0);
        v[15] = mk(1, 0,  'h050, 1, 2, 1, 'hC0,       'hF, 0,      2, 0, 0, 0, 0);
        v[16] = mk(0, 1,  'h050, 1, 2, 1, 0,          0,   0,      0, 'hC0, 'hC1, 0, 0);
        v[17] = mk(1, 2,  'h3FC, 0, 2, 1, 'h77,       'hF, 0,      0, 0, 0, 0, 0);
        v[18] = mk(0, 3,  'h3FC, 0, 2, 1, 0,          0,   0,      0, 'h77, 0, 0, 0);
        v[19] = mk(1, 4,  'h060, 1, 2, 1, 'hD0,       'hF, 'h1FF,  2, 0, 0, 0, 0);

        repeat (2) @(negedge clock);
        chk("rst_awready", 64'(ifc.awready), 64'(1));
        chk("rst_arready", 64'(ifc.arready), 64'(1));
        chk("rst_wready", 64'(ifc.wready), 64'(0));
        chk("rst_bvalid", 64'(ifc.bvalid), 64'(0));
        chk("rst_rvalid", 64'(ifc.rvalid), 64'(0));
        chk("rst_rlast", 64'(ifc.rlast), 64'(0));
        chk("rst_bresp", 64'(ifc.bresp), 64'(0));
        chk("rst_rresp", 64'(ifc.rresp), 64'(0));
        chk("rst_bid", 64'(ifc.bid), 64'(0));
        chk("rst_rid", 64'(ifc.rid), 64'(0));
        chk("rst_rdata", 64'(ifc.rdata), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 20; i++)
            if (v[i].wr) do_write(v[i], i % 3);
            else do_read(v[i], 1'b0);

        do_write(mk(1, 5, 'h100, 15, 2, 1, 'h5000, 'hF, 15, 0, 0, 0, 0, 0), 4);
        do_read(mk(0, 6, 'h100, 15, 2, 1, 'h5000, 0, 0, 0, 0, 0, 0, 0), 1'b1);

        do_write(mk(1, 7, 'h200, 7, 2, 1, 'h7000, 'hF, 7, 0, 0, 0, 0, 0), 0);
        @(negedge clock);
        ifc.arid = 4'h9; ifc.araddr = 12'h200; ifc.arlen = 8'd7; ifc.arsize = 3'd2; ifc.arburst = 2'd1;
        ifc.arvalid = 1'b1;
        for (int k = 0; k < 100 && !ifc.arready; k++) @(negedge clock);
        @(negedge clock);
        ifc.arvalid = 1'b0;
        ifc.rready = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_beat2", 64'(ifc.rdata), 64'(32'h7002));
        reset = 1'b1;
        ifc.rready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rvalid", 64'(ifc.rvalid), 64'(0));
        chk("mid_arready", 64'(ifc.arready), 64'(1));
        chk("mid_rlast", 64'(ifc.rlast), 64'(0));
        chk("mid_rdata", 64'(ifc.rdata), 64'(0));
        chk("mid_rid", 64'(ifc.rid), 64'(0));
        do_read(mk(0, 10, 'h200, 7, 2, 1, 'h7000, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
